// File: rtl/pixel_window_builder.sv
// ============================================================================
// Module   : pixel_window_builder
// Purpose  : Builds 3x3 pixel windows from a raster pixel stream using two
//            line buffers and a 3x3 shift register. One window per accepted
//            pixel once two full rows and two columns have been seen.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            in_valid/in_ready - raster pixel handshake
//            in_pixel, in_sof  - pixel value, start-of-frame marker
//            win_valid/win_ready - window handshake
//            win_pixels        - 9 elements, element k at [k*PIXEL_W +: PIXEL_W],
//                                k = r*3+c (r=0 top, c=0 left), k=4 is centre
//            win_x, win_y      - window centre coordinates
//            win_eof           - last window of the frame
//            frame_err         - one-cycle pulse on misplaced in_sof
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_window_builder #(
  parameter int PIXEL_W = 8,
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PIXEL_W-1:0]         in_pixel,
  input  logic                       in_sof,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [9*PIXEL_W-1:0]       win_pixels,
  output logic [$clog2(IMG_W)-1:0]   win_x,
  output logic [$clog2(IMG_H)-1:0]   win_y,
  output logic                       win_eof,
  output logic                       frame_err
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] c_x_last = XW'(IMG_W - 1);
  localparam logic [YW-1:0] c_y_last = YW'(IMG_H - 1);

  // Row-phase of the frame; derived from the row counter, not registered.
  localparam logic [0:0] c_st_fill   = 1'b0;
  localparam logic [0:0] c_st_active = 1'b1;

  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [PIXEL_W-1:0] lb0_q [IMG_W];
  logic [PIXEL_W-1:0] lb1_q [IMG_W];
  logic [PIXEL_W-1:0] win_q [9];
  logic               win_valid_q;
  logic [XW-1:0]      win_x_q;
  logic [YW-1:0]      win_y_q;
  logic               win_eof_q;
  logic               frame_err_q;

  logic               w_accept;
  logic [XW-1:0]      w_ex;
  logic [YW-1:0]      w_ey;
  logic [0:0]         w_state;
  logic               w_emit;
  logic               w_sof_err;
  logic [PIXEL_W-1:0] w_lb0_rd;
  logic [PIXEL_W-1:0] w_lb1_rd;

  // A single output register: a new pixel may enter whenever the window
  // slot is empty or being drained this cycle.
  assign in_ready = !win_valid_q || win_ready;
  assign w_accept = in_valid && in_ready;

  // An accepted in_sof forces the pixel to (0,0) regardless of the counters,
  // which also abandons any partial frame (it restarts in FILL).
  assign w_ex      = in_sof ? '0 : x_q;
  assign w_ey      = in_sof ? '0 : y_q;
  assign w_sof_err = w_accept && in_sof && ((x_q != '0) || (y_q != '0));

  assign w_state = (w_ey >= YW'(2)) ? c_st_active : c_st_fill;
  assign w_emit  = w_accept && (w_state == c_st_active) && (w_ex >= XW'(2));

  assign w_lb0_rd = lb0_q[w_ex];
  assign w_lb1_rd = lb1_q[w_ex];

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (w_accept) begin
      if (w_ex == c_x_last) begin
        x_d = '0;
        y_d = (w_ey == c_y_last) ? '0 : w_ey + YW'(1);
      end else begin
        x_d = w_ex + XW'(1);
        y_d = w_ey;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      win_valid_q <= 1'b0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      win_eof_q   <= 1'b0;
      frame_err_q <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      frame_err_q <= w_sof_err;
      // Accept implies the output slot is free, so shifting never disturbs
      // a window that is still waiting for win_ready.
      if (w_accept) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r*3]     <= win_q[r*3 + 1];
          win_q[r*3 + 1] <= win_q[r*3 + 2];
        end
        win_q[2] <= w_lb1_rd;
        win_q[5] <= w_lb0_rd;
        win_q[8] <= in_pixel;
      end
      if (w_emit) begin
        win_valid_q <= 1'b1;
        win_x_q     <= w_ex - XW'(1);
        win_y_q     <= w_ey - YW'(1);
        win_eof_q   <= (w_ex == c_x_last) && (w_ey == c_y_last);
      end else if (win_ready) begin
        win_valid_q <= 1'b0;
        win_eof_q   <= 1'b0;
      end
    end
  end

  // Line buffers are not reset: FILL rows rewrite every entry before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      lb1_q[w_ex] <= w_lb0_rd;
      lb0_q[w_ex] <= in_pixel;
    end
  end

  generate
    for (genvar k = 0; k < 9; k++) begin : g_pack
      assign win_pixels[k*PIXEL_W +: PIXEL_W] = win_q[k];
    end
  endgenerate

  assign win_valid = win_valid_q;
  assign win_x     = win_x_q;
  assign win_y     = win_y_q;
  assign win_eof   = win_eof_q;
  assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_pixel_window_builder.sv
// ============================================================================
// Module   : tb_pixel_window_builder
// Purpose  : Self-checking bench for pixel_window_builder on a 4x4 image.
//            A frame-image model predicts every window from pixel positions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_window_builder;

  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  typedef struct packed {
    logic [9*PW-1:0] pix;
    logic [1:0]      x;
    logic [1:0]      y;
    logic            eof;
  } win_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_pixel = '0;
  logic          in_sof = 1'b0;
  logic          win_valid;
  logic          win_ready = 1'b1;
  logic [9*PW-1:0] win_pixels;
  logic [1:0]    win_x;
  logic [1:0]    win_y;
  logic          win_eof;
  logic          frame_err;

  pixel_window_builder #(.PIXEL_W(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_sof(in_sof), .win_valid(win_valid),
    .win_ready(win_ready), .win_pixels(win_pixels), .win_x(win_x),
    .win_y(win_y), .win_eof(win_eof), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  int drv_to = 0;
  int stalls = 0;
  int exp_ferr = 0;
  int obs_ferr = 0;

  // Model: position in frame plus a copy of the frame image.
  int         mx = 0;
  int         my = 0;
  logic [PW-1:0] img [H][W];
  win_t exp_q[$];
  win_t obs_q[$];
  int   acc_cyc[$];
  int   obs_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      mx = 0;
      my = 0;
    end else begin
      if (in_valid && in_ready) begin
        if (in_sof) begin
          if (mx != 0 || my != 0) exp_ferr++;
          mx = 0;
          my = 0;
        end
        img[my][mx] = in_pixel;
        if (mx >= 2 && my >= 2) begin
          win_t e;
          for (int k = 0; k < 9; k++)
            e.pix[k*PW +: PW] = img[my-2+k/3][mx-2+k%3];
          e.x   = 2'(mx - 1);
          e.y   = 2'(my - 1);
          e.eof = (mx == W-1) && (my == H-1);
          exp_q.push_back(e);
        end
        acc_cyc.push_back(cyc);
        mx++;
        if (mx == W) begin
          mx = 0;
          my = (my == H-1) ? 0 : my + 1;
        end
      end
      if (win_valid && win_ready) begin
        obs_q.push_back('{pix: win_pixels, x: win_x, y: win_y, eof: win_eof});
        obs_cyc.push_back(cyc);
      end
      if (frame_err) obs_ferr++;
      if (in_valid && !in_ready) stalls++;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the pixel is taken,
  // leaving in_valid high so consecutive calls stream without gaps.
  task automatic send_px(input logic [PW-1:0] p, input logic sof);
    int n = 0;
    in_valid = 1'b1;
    in_pixel = p;
    in_sof   = sof;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) drv_to++;
    @(posedge clk);
    #1;
    in_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_scoreboard();
    exp_q.delete();
    obs_q.delete();
    acc_cyc.delete();
    obs_cyc.delete();
    stalls   = 0;
    exp_ferr = 0;
    obs_ferr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (win_valid !== 1'b0) begin n_err++; $display("FAIL reset_win_valid: got %b want 0", win_valid); end
    n_chk++; if (win_eof !== 1'b0) begin n_err++; $display("FAIL reset_win_eof: got %b want 0", win_eof); end
    n_chk++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_chk++; if (win_pixels !== '0) begin n_err++; $display("FAIL reset_win_pixels: got %h want 0", win_pixels); end
    n_chk++; if (win_x !== 2'd0 || win_y !== 2'd0) begin n_err++; $display("FAIL reset_win_xy: got %0d,%0d want 0,0", win_x, win_y); end
    n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
  endtask

  task automatic test_single_frame();
    logic [9*PW-1:0] first_exp;
    logic [9*PW-1:0] last_exp;
    clear_scoreboard();
    for (int i = 0; i < W*H; i++) send_px(PW'(i), i == 0);
    idle(6);
    for (int k = 0; k < 9; k++) begin
      first_exp[k*PW +: PW] = PW'((k/3)*4 + k%3);
      last_exp[k*PW +: PW]  = PW'((k/3+1)*4 + k%3 + 1);
    end
    n_chk++; if (obs_q.size() != 4) begin n_err++; $display("FAIL single_count: got %0d want 4", obs_q.size()); end
    if (obs_q.size() == 4) begin
      n_chk++; if (obs_q[0].pix !== first_exp || obs_q[0].x !== 2'd1 || obs_q[0].y !== 2'd1)
        begin n_err++; $display("FAIL single_first: got %h (%0d,%0d) want %h (1,1)", obs_q[0].pix, obs_q[0].x, obs_q[0].y, first_exp); end
      n_chk++; if (obs_q[3].pix !== last_exp || obs_q[3].x !== 2'd2 || obs_q[3].y !== 2'd2 || obs_q[3].eof !== 1'b1)
        begin n_err++; $display("FAIL single_last: got %h (%0d,%0d) eof=%b want %h (2,2) eof=1", obs_q[3].pix, obs_q[3].x, obs_q[3].y, obs_q[3].eof, last_exp); end
      n_chk++; if (obs_q[0].eof !== 1'b0 || obs_q[1].eof !== 1'b0 || obs_q[2].eof !== 1'b0)
        begin n_err++; $display("FAIL single_eof_early: got %b%b%b want 000", obs_q[0].eof, obs_q[1].eof, obs_q[2].eof); end
      n_chk++; if (obs_cyc[0] != acc_cyc[10] + 1)
        begin n_err++; $display("FAIL single_latency: got cycle %0d want %0d", obs_cyc[0], acc_cyc[10] + 1); end
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL single_win%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    clear_scoreboard();
    win_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < W*H; i++) send_px(PW'(i), i == 0);
        in_valid = 1'b0;
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!win_valid && n < 100) begin @(negedge clk); n++; end
        n_chk++;
        if (!win_valid) begin
          n_err++; $display("FAIL bp_wait_window: got win_valid=0 want 1");
        end else begin
          for (int k = 0; k < 5; k++) begin
            n_chk++; if (in_ready !== 1'b0 || win_valid !== 1'b1)
              begin n_err++; $display("FAIL bp_stall%0d: got in_ready=%b win_valid=%b want 0,1", k, in_ready, win_valid); end
            n_chk++; if (win_pixels !== exp_q[0].pix || win_x !== exp_q[0].x || win_y !== exp_q[0].y || win_eof !== exp_q[0].eof)
              begin n_err++; $display("FAIL bp_hold%0d: got %h (%0d,%0d) want %h (%0d,%0d)", k, win_pixels, win_x, win_y, exp_q[0].pix, exp_q[0].x, exp_q[0].y); end
            if (k < 4) @(negedge clk);
          end
        end
        @(posedge clk);
        #1 win_ready = 1'b1;
      end
    join
    idle(10);
    n_chk++; if (obs_q.size() != 4) begin n_err++; $display("FAIL bp_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_win%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_sof_error();
    clear_scoreboard();
    for (int i = 0; i < 6; i++) send_px(PW'($urandom), i == 0);
    for (int i = 0; i < W*H; i++) send_px(PW'($urandom), i == 0);
    idle(6);
    n_chk++; if (obs_ferr != 1) begin n_err++; $display("FAIL sof_frame_err_cycles: got %0d want 1", obs_ferr); end
    n_chk++; if (obs_ferr != exp_ferr) begin n_err++; $display("FAIL sof_frame_err_model: got %0d want %0d", obs_ferr, exp_ferr); end
    n_chk++; if (obs_q.size() != 4) begin n_err++; $display("FAIL sof_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL sof_win%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_rst_midframe();
    clear_scoreboard();
    for (int i = 0; i < 10; i++) send_px(PW'($urandom), i == 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    clear_scoreboard();
    // No in_sof here: reset alone must return the counters to (0,0).
    for (int i = 0; i < W*H; i++) send_px(PW'($urandom), 1'b0);
    idle(6);
    n_chk++; if (obs_q.size() != 4) begin n_err++; $display("FAIL rst_count: got %0d want 4", obs_q.size()); end
    if (obs_q.size() > 0 && acc_cyc.size() > 10) begin
      n_chk++; if (obs_cyc[0] != acc_cyc[10] + 1)
        begin n_err++; $display("FAIL rst_first_cycle: got %0d want %0d", obs_cyc[0], acc_cyc[10] + 1); end
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rst_win%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_scoreboard();
    for (int i = 0; i < 2*W*H; i++) send_px(PW'($urandom), (i % (W*H)) == 0);
    idle(6);
    n_chk++; if (stalls != 0) begin n_err++; $display("FAIL b2b_stalls: got %0d want 0", stalls); end
    n_chk++; if (obs_q.size() != 8) begin n_err++; $display("FAIL b2b_count: got %0d want 8", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_win%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
      if (i < acc_cyc.size() && obs_cyc.size() > i) begin
        // Window i comes from accept index (i/4)*16 + 10 + (i%4/2)*4 + i%2.
        int a = (i/4)*16 + 10 + ((i%4)/2)*4 + (i%2);
        n_chk++; if (obs_cyc[i] != acc_cyc[a] + 1)
          begin n_err++; $display("FAIL b2b_timing%0d: got %0d want %0d", i, obs_cyc[i], acc_cyc[a] + 1); end
      end
    end
  endtask

  task automatic test_random();
    bit done = 1'b0;
    clear_scoreboard();
    fork
      begin
        for (int i = 0; i < 3*W*H; i++) begin
          send_px(PW'($urandom), (i % (W*H)) == 0);
          if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 win_ready = 1'($urandom_range(0, 1));
        end
        win_ready = 1'b1;
      end
    join
    idle(10);
    n_chk++; if (obs_q.size() != 12) begin n_err++; $display("FAIL rand_count: got %0d want 12", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_win%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_sof_error();
    test_rst_midframe();
    test_back_to_back();
    test_random();
    n_chk++; if (drv_to != 0) begin n_err++; $display("FAIL driver_timeout: got %0d want 0", drv_to); end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pixel_window_builder.md
PIXEL_WINDOW_BUILDER -- requirements
Module: pixel_window_builder

Interface
REQ-001 SHALL have parameter PIXEL_W, default 8, bits per pixel.
REQ-002 SHALL have parameter IMG_W, default 64, pixels per row; legal range 3 or more.
REQ-003 SHALL have parameter IMG_H, default 64, rows per frame; legal range 3 or more.
REQ-004 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1 bit, raster pixel present.
REQ-007 SHALL have port in_ready, output, 1 bit, block can accept a pixel.
REQ-008 SHALL have port in_pixel, input, PIXEL_W bits, raster pixel value.
REQ-009 SHALL have port in_sof, input, 1 bit, pixel is frame position (0,0).
REQ-010 SHALL have port win_valid, output, 1 bit, 3x3 window present.
REQ-011 SHALL have port win_ready, input, 1 bit, downstream image processor accepts the window.
REQ-012 SHALL have port win_pixels, output, 9*PIXEL_W bits, window; element index r*3+c (r=0 top row, c=0 left column); element 4 is the centre pixel.
REQ-013 SHALL have port win_x, output, clog2(IMG_W) bits, centre column.
REQ-014 SHALL have port win_y, output, clog2(IMG_H) bits, centre row.
REQ-015 SHALL have port win_eof, output, 1 bit, last window of frame.
REQ-016 SHALL have port frame_err, output, 1 bit, one-cycle pulse on misplaced in_sof.

Function
REQ-017 Accept SHALL occur on cycles with in_valid && in_ready.
REQ-018 in_ready SHALL equal !win_valid || win_ready (single output register, full throughput).
REQ-019 Column counter x SHALL run 0..IMG_W-1 and row counter y SHALL run 0..IMG_H-1, both advancing per accept.
- x wraps to 0 and increments y.
- At (IMG_W-1, IMG_H-1), both counters wrap to 0.
REQ-020 Two line buffers of IMG_W entries SHALL hold rows y-1 (lb0) and y-2 (lb1).
- On accept: lb1[x] <= lb0[x]; lb0[x] <= in_pixel.
REQ-021 On accept, the window SHALL shift one column left; new right column = {lb1[x], lb0[x], in_pixel} (top, mid, bottom).
REQ-022 State FILL SHALL hold while y<2; state ACTIVE SHALL hold while y>=2; the state is derived from the counter. No windows SHALL be emitted in FILL.
REQ-023 An accept at (x,y) with x>=2 and y>=2 SHALL set win_valid on the next cycle.
- Window centre: win_x=x-1, win_y=y-1.
- Windows per frame: (IMG_W-2)*(IMG_H-2).
- Latency: 1 cycle.
REQ-024 win_eof SHALL be 1 exactly with the window centred at (IMG_W-2, IMG_H-2).
REQ-025 win_valid, win_pixels, win_x, win_y and win_eof SHALL hold stable while win_valid && !win_ready.
REQ-026 win_valid SHALL clear after a handshake unless a new window is produced in the same cycle.
REQ-027 An accept with in_sof=1 SHALL treat the pixel as (0,0); counters continue from (1,0).
REQ-028 If in_sof=1 is accepted while the counters are not at (0,0), frame_err SHALL pulse for 1 cycle.
- The partial frame SHALL be abandoned with no further windows from it.
- A pending win_valid SHALL still complete normally.
REQ-029 An accept with in_sof=0 at counters (0,0) SHALL be legal; in_sof is optional.
REQ-030 No arithmetic SHALL be applied to pixel values; data SHALL pass unmodified at PIXEL_W bits.

Reset
REQ-031 While rst=1, the following SHALL be set: win_valid=0, win_eof=0, frame_err=0, x=y=0, window registers=0, win_x=win_y=0.
REQ-032 Line buffer contents SHALL NOT be reset; FILL gating makes them don't-care.
REQ-033 rst mid-frame SHALL discard any pending window; the next accepted pixel is (0,0).

Verification (IMG_W=4, IMG_H=4, PIXEL_W=8, in_pixel=y*4+x, win_ready=1 unless stated)
REQ-034 Stream one frame -> first win_valid one cycle after pixel 10 is accepted.
- win_pixels = {0,1,2,4,5,6,8,9,10}, win_x=1, win_y=1.
- Exactly 4 windows total.
REQ-035 Same frame -> last window centre (2,2) with win_pixels {5,6,7,9,10,11,13,14,15} and win_eof=1; win_eof=0 on all other windows.
REQ-036 win_ready=0 for 5 cycles during the first window -> in_ready=0 and outputs stable for those cycles; after release, all 4 windows arrive in order with none lost or duplicated.
REQ-037 in_sof=1 asserted on the 7th pixel of a frame -> frame_err pulses for 1 cycle; a following full 16-pixel frame yields exactly 4 correct windows.
REQ-038 rst pulsed after 10 pixels, then a full frame streamed -> no window before pixel 10 of the new frame; 4 correct windows follow.
REQ-039 Two back-to-back frames with in_valid held at 1 -> 8 windows, with no bubbles beyond the FILL rows.
